// File: rtl/module_scan_display_if.sv
// Bus bundle for module_scan_display: the four digit segment codes with
// their load strobe going in, and the multiplexed display drive coming out.
interface module_scan_display_if;
  logic [6:0] seg_unidades;
  logic [6:0] seg_decenas;
  logic [6:0] seg_centenas;
  logic [6:0] seg_milesimas;
  logic       listo;
  logic [6:0] seg_out;
  logic [3:0] an;
  logic       frame;

  modport master (
    output seg_unidades, seg_decenas, seg_centenas, seg_milesimas, listo,
    input  seg_out, an, frame
  );

  modport slave (
    input  seg_unidades, seg_decenas, seg_centenas, seg_milesimas, listo,
    output seg_out, an, frame
  );
endinterface

// File: rtl/module_scan_display.sv
// Four-digit multiplexed 7-segment scanner. Each digit is lit for
// DIGIT_CYCLES clocks, optionally followed by BLANK_CYCLES dark clocks.
// New digit values are double-buffered and only take effect at the start of
// a frame (unidades slot), so a frame never shows a mix of old and new data.
// Optional feature: define SCAN_LEADING_ZERO_BLANK_EN to darken leading zeros.
module module_scan_display #(
  parameter int DIGIT_CYCLES = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input logic                  clk,
  input logic                  rst,
  module_scan_display_if.slave bus
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [0:0] ST_ON    = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  localparam logic [6:0] SEG_ZERO = 7'b111_1110;

  logic [0:0]    r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_disp [4];
  logic [6:0]    r_pend [4];
  logic          r_pend_valid;
  logic [6:0]    r_seg_out;
  logic [3:0]    r_an;
  logic          r_frame;

  logic [6:0]    w_in        [4];
  logic [6:0]    w_disp_next [4];
  logic [3:0]    w_dark;
  logic          w_commit;
  logic          w_last_on;
  logic          w_last_blank;

  // Gather inputs by digit index and decode slot-boundary conditions.
  always_comb begin
    w_in[0]      = bus.seg_unidades;
    w_in[1]      = bus.seg_decenas;
    w_in[2]      = bus.seg_centenas;
    w_in[3]      = bus.seg_milesimas;
    w_commit     = (r_state == ST_ON) && (r_idx == 2'd0) && (r_cnt == '0);
    w_last_on    = (r_cnt == CW'(DIGIT_CYCLES - 1));
    w_last_blank = (r_cnt == CW'(BLANK_CYCLES - 1));
  end

  // Display contents for the slot being emitted; a same-cycle strobe at
  // frame start bypasses the pending buffer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_disp_next = r_disp;
    if (w_commit) begin
      if (bus.listo)        w_disp_next = w_in;
      else if (r_pend_valid) w_disp_next = r_pend;
    end
  end

  // Leading-zero suppression mask; unidades is never suppressed.
  always_comb begin
`ifdef SCAN_LEADING_ZERO_BLANK_EN
    w_dark[3] = (w_disp_next[3] == SEG_ZERO);
    w_dark[2] = w_dark[3] && (w_disp_next[2] == SEG_ZERO);
    w_dark[1] = w_dark[2] && (w_disp_next[1] == SEG_ZERO);
    w_dark[0] = 1'b0;
`else
    w_dark = 4'b0000;
`endif
  end

  // Scan sequencer: ON/BLANK slot timing and digit index advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ON;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
    end else if (r_state == ST_ON) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (w_last_on) begin
        r_cnt <= '0;
        if (BLANK_CYCLES > 0) r_state <= ST_BLANK;
        else                  r_idx   <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      if (w_last_blank) begin
        r_cnt   <= '0;
        r_state <= ST_ON;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Double buffer: capture on strobe, commit at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these small register arrays are reset on purpose so a digit
      // zero is displayed after reset and stale pending data is discarded.
      for (int i = 0; i < 4; i++) begin
        r_disp[i] <= SEG_ZERO;
        r_pend[i] <= SEG_ZERO;
      end
      r_pend_valid <= 1'b0;
    end else begin
      r_disp <= w_disp_next;
      if (w_commit) begin
        r_pend_valid <= 1'b0;
      end else if (bus.listo) begin
        r_pend       <= w_in;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Registered display drive and frame-start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an      <= 4'b1111;
      r_seg_out <= 7'b000_0000;
      r_frame   <= 1'b0;
    end else begin
      r_frame <= w_commit;
      if ((r_state == ST_ON) && !w_dark[r_idx]) begin
        r_an      <= ~(4'b0001 << r_idx);
        r_seg_out <= w_disp_next[r_idx];
      end else begin
        r_an      <= 4'b1111;
        r_seg_out <= 7'b000_0000;
      end
    end
  end

  assign bus.an      = r_an;
  assign bus.seg_out = r_seg_out;
  assign bus.frame   = r_frame;

endmodule

// File: tb/tb_module_scan_display.sv
// Self-checking bench for module_scan_display with DIGIT_CYCLES=4,
// BLANK_CYCLES=2 (24-cycle frame). A position-arithmetic model predicts the
// outputs every cycle; directed literal checks pin key points of the scan.
module tb_module_scan_display;

  localparam int DC    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = DC + BC;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] S0 = 7'b111_1110;
  localparam logic [6:0] S1 = 7'b011_0000;
  localparam logic [6:0] S2 = 7'b110_1101;
  localparam logic [6:0] S3 = 7'b111_1001;
  localparam logic [6:0] S4 = 7'b011_0011;
  localparam logic [6:0] S5 = 7'b101_1011;
  localparam logic [6:0] S7 = 7'b111_0000;
  localparam logic [6:0] S8 = 7'b111_1111;
  localparam logic [6:0] S9 = 7'b111_1011;

`ifdef SCAN_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   obs    = -1;

  module_scan_display_if bus ();

  module_scan_display #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_t;
  logic [6:0] m_disp [4];
  logic [6:0] m_pend [4];
  logic       m_pv;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_frame;

  function automatic bit is_dark(int slot, logic [6:0] d [4]);
    if (!LZB || slot == 0) return 1'b0;
    for (int k = slot; k < 4; k++)
      if (d[k] != S0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int         p;
    int         slot;
    logic [6:0] nd   [4];
    logic [6:0] in_v [4];
    if (rst) begin
      m_t     <= 0;
      m_pv    <= 1'b0;
      e_an    <= 4'b1111;
      e_seg   <= 7'd0;
      e_frame <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_disp[i] <= S0;
        m_pend[i] <= S0;
      end
    end else begin
      in_v = '{bus.seg_unidades, bus.seg_decenas, bus.seg_centenas, bus.seg_milesimas};
      p    = m_t % FRAME;
      slot = p / SLOT;
      nd   = m_disp;
      if (p == 0) begin
        if (bus.listo) nd = in_v;
        else if (m_pv) nd = m_pend;
        m_pv <= 1'b0;
      end else if (bus.listo) begin
        m_pend <= in_v;
        m_pv   <= 1'b1;
      end
      m_disp  <= nd;
      e_frame <= (p == 0);
      if ((p % SLOT) < DC && !is_dark(slot, nd)) begin
        e_an  <= ~(4'b0001 << slot);
        e_seg <= nd[slot];
      end else begin
        e_an  <= 4'b1111;
        e_seg <= 7'd0;
      end
      m_t <= m_t + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_vec++;
      if ({bus.an, bus.seg_out, bus.frame} !== {e_an, e_seg, e_frame}) begin
        n_miss++;
        $display("FAIL model obs=%0d: an=%b seg=%b frame=%b, expected an=%b seg=%b frame=%b",
                 obs, bus.an, bus.seg_out, bus.frame, e_an, e_seg, e_frame);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (obs=%0d): got %0h, expected %0h", name, obs, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    obs++;
  endtask

  task automatic goto(input int target);
    while (obs < target) step();
  endtask

  // One-cycle strobe, then junk on the data inputs that must be ignored.
  task automatic strobe(input logic [6:0] u, d, c, m);
    bus.seg_unidades  = u;
    bus.seg_decenas   = d;
    bus.seg_centenas  = c;
    bus.seg_milesimas = m;
    bus.listo         = 1'b1;
    step();
    bus.listo         = 1'b0;
    bus.seg_unidades  = 7'h55;
    bus.seg_decenas   = 7'h2A;
    bus.seg_centenas  = 7'h11;
    bus.seg_milesimas = 7'h66;
  endtask

  task automatic check_slot(input string name, input logic [3:0] an_exp, input logic [6:0] seg_exp);
    check({name, ".an"},  {28'd0, bus.an},      {28'd0, an_exp});
    check({name, ".seg"}, {25'd0, bus.seg_out}, {25'd0, seg_exp});
  endtask

  initial begin
    bus.seg_unidades  = S0;
    bus.seg_decenas   = S0;
    bus.seg_centenas  = S0;
    bus.seg_milesimas = S0;
    bus.listo         = 1'b0;
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_slot("reset", 4'b1111, 7'd0);
    check("reset.frame", {31'd0, bus.frame}, 32'd0);
    rst = 1'b0;
    obs = -1;

    // Idle scan of zeros.
    step();
    check_slot("first", 4'b1110, S0);
    check("first.frame", {31'd0, bus.frame}, 32'd1);
    goto(1);  check("frame_once", {31'd0, bus.frame}, 32'd0);
    goto(4);  check_slot("blank0", 4'b1111, 7'd0);
    goto(6);  check_slot("dec_zero", LZB ? 4'b1111 : 4'b1101, LZB ? 7'd0 : S0);
    goto(18); check_slot("mil_zero", LZB ? 4'b1111 : 4'b0111, LZB ? 7'd0 : S0);
    goto(23); check_slot("blank3", 4'b1111, 7'd0);
    goto(24); check("frame24", {31'd0, bus.frame}, 32'd1);
    check_slot("u_frame2", 4'b1110, S0);

    // Load 1,2,3,4 during idx=2 ON; current frame keeps zeros.
    goto(36); strobe(S1, S2, S3, S4);
    goto(42); check_slot("no_tear", LZB ? 4'b1111 : 4'b0111, LZB ? 7'd0 : S0);
    goto(48); check_slot("u1", 4'b1110, S1);
    goto(54); check_slot("d2", 4'b1101, S2);
    goto(60); check_slot("c3", 4'b1011, S3);

    // Two strobes in one frame: last wins.
    goto(50); strobe(S5, S5, S5, S5);
    goto(60); strobe(S7, S7, S7, S7);
    goto(66); check_slot("m4", 4'b0111, S4);
    goto(72); check_slot("last_u", 4'b1110, S7);
    goto(90); check_slot("last_m", 4'b0111, S7);

    // Strobe in the frame=1 cycle: commits at the following frame.
    goto(96);  check("frame96", {31'd0, bus.frame}, 32'd1);
    strobe(S8, S8, S8, S8);
    goto(102); check_slot("wait8", 4'b1101, S7);
    goto(120); check_slot("show8", 4'b1110, S8);
    goto(138); check_slot("show8m", 4'b0111, S8);

    // Strobe on the commit edge: shown immediately.
    goto(143); strobe(S9, S9, S9, S9);
    check_slot("bypass", 4'b1110, S9);
    check("bypass.frame", {31'd0, bus.frame}, 32'd1);

    // Pending data then reset mid idx=1 ON.
    goto(146); strobe(S1, S1, S1, S1);
    goto(151); check_slot("pre_rst", 4'b1101, S9);
    rst = 1'b1;
    #1 check_slot("in_rst", 4'b1111, 7'd0);
    @(negedge clk);
    @(negedge clk);
    check("in_rst.frame", {31'd0, bus.frame}, 32'd0);
    rst = 1'b0;
    obs = -1;
    step();
    check_slot("restart", 4'b1110, S0);
    check("restart.frame", {31'd0, bus.frame}, 32'd1);
    goto(24); check_slot("discarded", 4'b1110, S0);

    // Leading-zero pattern m,c,d,u = 0,0,4,0.
    goto(26); strobe(S0, S4, S0, S0);
    goto(48); check_slot("lz_u", 4'b1110, S0);
    goto(54); check_slot("lz_d", 4'b1101, S4);
    goto(60); check_slot("lz_c", LZB ? 4'b1111 : 4'b1011, LZB ? 7'd0 : S0);
    goto(66); check_slot("lz_m", LZB ? 4'b1111 : 4'b0111, LZB ? 7'd0 : S0);
    goto(70);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/module_scan_display.md
MODULE_SCAN_DISPLAY -- requirements
Module: module_scan_display

Interface
REQ-001 Parameter DIGIT_CYCLES, default 27000, clock cycles each digit is lit (>=1).
REQ-002 Parameter BLANK_CYCLES, default 270, inter-digit dark cycles (>=0; 0 = no blank slot).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seg_unidades / seg_decenas / seg_centenas / seg_milesimas  input  7 each  active-high segment codes, bit6=a..bit0=g; digit zero = 7'b111_1110.
REQ-006 listo  input  1  one-cycle strobe: the four segment inputs are valid this cycle.
REQ-007 seg_out  output  7  shared segment bus, active-high, registered.
REQ-008 an  output  4  digit enables, active-low one-hot, registered; an[0]=unidades, an[1]=decenas, an[2]=centenas, an[3]=milesimas.
REQ-009 frame  output  1  registered one-cycle pulse when a new frame starts (unidades slot entry).

Function
REQ-010 Scanner FSM states: ON and BLANK; 2-bit digit index idx; cycle counter cnt wide enough for max(DIGIT_CYCLES, BLANK_CYCLES)-1.
REQ-011 ON lasts exactly DIGIT_CYCLES cycles; then BLANK if BLANK_CYCLES>0, else ON of next digit.
REQ-012 BLANK lasts exactly BLANK_CYCLES cycles; then ON with idx+1.
REQ-013 idx order 0,1,2,3, wraps 3 -> 0; frame period = 4*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
REQ-014 Outputs registered: in ON for idx, an = ~(4'b0001 << idx), seg_out = disp[idx]; in BLANK, an = 4'b1111, seg_out = 7'b000_0000.
REQ-015 Input capture: listo=1 loads the four inputs into pending registers and sets pending_valid; a later listo before commit overwrites (last wins).
REQ-016 Commit: on each entry into ON with idx=0, if pending_valid, disp[0..3] <= pending and pending_valid clears; displayed digits never change mid-frame (no tearing).
REQ-017 Simultaneous listo and commit cycle: current-cycle inputs go straight to disp, pending_valid ends 0.
REQ-018 frame pulses high for exactly the first ON cycle of idx=0 (including the first one after reset).
REQ-019 listo with no change in data still causes a commit; inputs are not sampled when listo=0.

Reset
REQ-020 While rst=1: an=4'b1111, seg_out=7'b000_0000, frame=0, state=ON, idx=0, cnt=0, pending_valid=0, disp[0..3] and pending all 7'b111_1110.
REQ-021 Reset mid-frame aborts the scan immediately; any uncommitted pending data is discarded.
REQ-022 First rising edge after rst release: an=4'b1110, seg_out=7'b111_1110, frame=1.

Configuration
REQ-023 Macro SCAN_LEADING_ZERO_BLANK_EN defined: milesimas dark if its code is 7'b111_1110; centenas dark if it and milesimas are zero codes; decenas dark if it, centenas and milesimas are zero codes; unidades never dark.
REQ-024 A dark digit keeps its full ON slot timing but drives an=4'b1111 and seg_out=7'b000_0000.
REQ-025 Macro undefined: all four digits always lit, zero codes displayed as-is; no extra logic.

Verification (DIGIT_CYCLES=4, BLANK_CYCLES=2)
REQ-026 Reset release, no listo -> an cycles 1110(4),1111(2),1101(4),1111(2),1011(4),1111(2),0111(4),1111(2), seg_out 7'b111_1110 in every ON slot, frame every 24 cycles.
REQ-027 listo with digits 1,2,3,4 (u..m) during idx=2 ON -> current frame still shows 0s; next frame shows 7'b011_0000, 7'b110_1101, 7'b111_1001, 7'b011_0011 on an[0..3].
REQ-028 Two listo strobes (codes of 5 then 7 on all digits) in one frame -> next frame shows only 7'b111_0000 on all digits.
REQ-029 listo asserted exactly in the frame=1 cycle with all digits 8 -> disp 7'b111_1111 from the next frame; pending_valid 0 afterwards.
REQ-030 rst pulsed mid idx=1 ON with pending data -> an=1111 during reset; after release scan restarts at idx=0 showing 7'b111_1110.
REQ-031 With SCAN_LEADING_ZERO_BLANK_EN, digits 0,0,4,0 (m,c,d,u) -> milesimas and centenas slots dark, decenas 7'b011_0011, unidades 7'b111_1110.
